// File: rtl/adder_xbit_digit_serial.sv
// Digit-serial adder/subtractor: one DIGIT_WIDTH-bit digit per clock, LSB first,
// behind valid/ready handshakes, reporting carry/borrow and signed overflow.
module adder_xbit_digit_serial #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  input  logic                  i_sub,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry,
  output logic                  o_ovf
);

  localparam int N     = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_digit_width
    $error("DIGIT_WIDTH must divide DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  c_q, c_d;
  logic                  sub_q, sub_d;
  logic                  cry_q, cry_d;
  logic                  ovf_q, ovf_d;

  logic [DIGIT_WIDTH-1:0] a_dig, b_dig;
  logic [DIGIT_WIDTH:0]   dsum;
  logic                   cin_msb;
  logic [DATA_WIDTH-1:0]  a_shift;

  // Operand A doubles as the accumulator: digits shift out at the bottom while
  // sum digits shift in at the top, so after N steps it holds the full result.
  always_comb begin
    a_dig   = a_q[DIGIT_WIDTH-1:0];
    b_dig   = b_q[DIGIT_WIDTH-1:0];
    dsum    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_WIDTH{1'b0}}, c_q};
    // Carry into a bit equals a ^ b ^ sum of that bit.
    cin_msb = a_dig[DIGIT_WIDTH-1] ^ b_dig[DIGIT_WIDTH-1] ^ dsum[DIGIT_WIDTH-1];
    a_shift = (a_q >> DIGIT_WIDTH)
            | (DATA_WIDTH'(dsum[DIGIT_WIDTH-1:0]) << (DATA_WIDTH - DIGIT_WIDTH));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sub_d   = sub_q;
    cry_d   = cry_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_num_a;
          b_d     = i_sub ? ~i_num_b : i_num_b;
          sub_d   = i_sub;
          c_d     = i_sub ^ i_cry;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        a_d   = a_shift;
        b_d   = b_q >> DIGIT_WIDTH;
        c_d   = dsum[DIGIT_WIDTH];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_DIGIT) begin
          res_d   = a_shift;
          cry_d   = sub_q ^ dsum[DIGIT_WIDTH];
          ovf_d   = cin_msb ^ dsum[DIGIT_WIDTH];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      cry_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      cry_q   <= cry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Working operands are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge i_clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_res   = res_q;
  assign o_cry   = cry_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_xbit_digit_serial.sv
// Directed bench for the digit-serial adder: 8-bit/2-bit-digit instance plus
// a degenerate single-digit 8-bit instance.
module tb_adder_xbit_digit_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, ready, cry, sub;
  logic [7:0] num_a, num_b;
  logic       o_ready, o_valid, o_cry, o_ovf;
  logic [7:0] o_res;

  logic       valid2, ready2, cry2, sub2;
  logic [7:0] num_a2, num_b2;
  logic       o_ready2, o_valid2, o_cry2, o_ovf2;
  logic [7:0] o_res2;

  int n_chk = 0;
  int n_err = 0;
  int lat;

  always #5 clk = ~clk;

  adder_xbit_digit_serial #(.DATA_WIDTH(8), .DIGIT_WIDTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_num_a(num_a), .i_num_b(num_b), .i_cry(cry), .i_sub(sub),
    .o_valid(o_valid), .i_ready(ready), .o_res(o_res), .o_cry(o_cry), .o_ovf(o_ovf)
  );

  adder_xbit_digit_serial #(.DATA_WIDTH(8), .DIGIT_WIDTH(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .o_ready(o_ready2),
    .i_num_a(num_a2), .i_num_b(num_b2), .i_cry(cry2), .i_sub(sub2),
    .o_valid(o_valid2), .i_ready(ready2), .o_res(o_res2), .o_cry(o_cry2), .o_ovf(o_ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one request, then scramble the inputs to show they are ignored.
  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    num_a = a; num_b = b; cry = c; sub = s; valid = 1'b1;
    tick();
    valid = 1'b0;
    num_a = 8'hC3; num_b = 8'h3C; cry = ~c; sub = ~s;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!o_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                    input logic c, input logic s,
                    input logic [7:0] er, input logic ec, input logic eo);
    int l;
    start(a, b, c, s);
    chk({tag, "_busy"}, {31'd0, o_ready}, 32'd0);
    wait_valid(l);
    chk({tag, "_lat"}, l, 32'd4);
    chk({tag, "_res"}, {24'd0, o_res}, {24'd0, er});
    chk({tag, "_cry"}, {31'd0, o_cry}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, o_ovf}, {31'd0, eo});
    tick();
    chk({tag, "_idle"}, {30'd0, o_valid, o_ready}, 32'd1);
    chk({tag, "_hold"}, {24'd0, o_res}, {24'd0, er});
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; ready = 1'b1; cry = 1'b0; sub = 1'b0;
    num_a = '0; num_b = '0;
    valid2 = 1'b0; ready2 = 1'b1; cry2 = 1'b0; sub2 = 1'b0; num_a2 = '0; num_b2 = '0;
    tick();
    tick();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_outs", {22'd0, o_res, o_cry, o_ovf}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'd0, o_ready}, 32'd1);

    op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
    op("add_7f_01c", 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
    op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
    op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    op("sub_10_01b", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b0, 1'b0);

    // Back-pressure with a competing request that must be dropped.
    ready = 1'b0;
    start(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid(lat);
    chk("bp_lat", lat, 32'd4);
    num_a = 8'hFF; num_b = 8'hFF; cry = 1'b1; sub = 1'b0; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
      chk("bp_res", {24'd0, o_res}, 32'h46);
    end
    valid = 1'b0; ready = 1'b1;
    tick();
    chk("bp_release", {30'd0, o_valid, o_ready}, 32'd1);
    tick();
    tick();
    chk("bp_not_queued", {30'd0, o_valid, o_ready}, 32'd1);
    chk("bp_res_kept", {24'd0, o_res}, 32'h46);
    op("after_bp", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

    // Reset in the middle of a calculation.
    start(8'hAA, 8'h55, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_res", {24'd0, o_res}, 32'h00);
    rst_n = 1'b1;
    tick();
    chk("midrst_ready", {30'd0, o_valid, o_ready}, 32'd1);
    op("after_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    // Single-digit instance.
    num_a2 = 8'hF0; num_b2 = 8'h20; cry2 = 1'b0; sub2 = 1'b0; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    lat = 0;
    while (!o_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    chk("n1_lat", lat, 32'd1);
    chk("n1_res", {24'd0, o_res2}, 32'h10);
    chk("n1_cry", {31'd0, o_cry2}, 32'd1);
    chk("n1_ovf", {31'd0, o_ovf2}, 32'd0);
    tick();
    chk("n1_idle", {30'd0, o_valid2, o_ready2}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
